seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between one always-on base source and two transient
//  requesters (src1 = alarm/status, src2 = message, highest priority). Latches requests, grants
//  the display for a fixed hold time, and drives the display's four digit nibbles plus a blink
//  blank flag. Sits between game/system logic and the display multiplexer.
// PARAMETERS
//  TICK_DIV  50000  clk cycles per 1 ms tick
//  HOLD_MS   2000   ticks a granted transient source owns the display
//  BLINK_MS  250    ticks per blink half-period
// PORTS
//  clk          in   1   system clock; the block's only clock
//  rst_l        in   1   reset; synchronous, active-high (1 = reset)
//  base_digits  in   16  live base value {a1,a2,a3,a4}, a1 = [15:12]
//  req          in   2   request levels, [0] = src1, [1] = src2; pending flag sets on 0->1 edge
//  req_digits1  in   16  src1 digits, sampled at grant
//  req_digits2  in   16  src2 digits, sampled at grant
//  blink_en     in   3   per-owner blink enable, [0] = base, [1] = src1, [2] = src2
//  ack          out  2   1-cycle pulse in the grant cycle for that source
//  owner        out  2   0 = base, 1 = src1, 2 = src2 (3 never driven)
//  busy         out  1   1 while a transient source owns the display
//  a1,a2,a3,a4  out  4   digit nibbles to the display
//  dig_blank    out  1   1 = downstream blanks all digits (blink off-phase)
// BEHAVIOUR
//  - Reset: state IDLE, pend = 0, req edge regs = 0, all outputs 0, prescaler/hold/blink cnt = 0, phase 0.
//  - Edge detect: req_q <= req; pend[i] sets when req[i] & ~req_q[i]. Pend clears on its own grant.
//  - FSM IDLE (owner 0): pend[1] -> SHOW2, else pend[0] -> SHOW1. SHOW1: pend[1] preempts -> SHOW2.
//    Preempted src1 is dropped, not requeued. SHOW2: new src2 edge retriggers the hold, reloads
//    req_digits2 and pulses ack[1]; no state change.
//  - Grant cycle: ack pulses; snapshot of req_digitsN taken; hold cnt and prescaler clear.
//  - Hold: counts ticks; at tick HOLD_MS -> expiry. Owner duration = exactly HOLD_MS*TICK_DIV cycles.
//  - Expiry: pend[1] -> SHOW2, elif pend[0] -> SHOW1, else IDLE. Same-cycle expiry and new edge:
//    the edge is pended first, then granted in that same transition.
//  - Simultaneous src1+src2 edges in IDLE: grant src2; src1 stays pending until src2 expires.
//  - Digits registered: owner/a1..a4 update the cycle after the FSM state changes (1-cycle latency).
//    In IDLE, base_digits pass live with the same 1-cycle latency. Transient owners show the snapshot.
//  - Blink: free-running; phase toggles every BLINK_MS ticks; not cleared at grant.
//    dig_blank = blink_en[owner] & phase (registered). Prescaler clears only at grant/reset.
//  - busy = (owner != 0). Any reset mid-hold returns to IDLE with pending discarded.
//  - Widths: hold cnt $clog2(HOLD_MS+1) bits; prescaler $clog2(TICK_DIV) bits; wrap at DIV-1.
// STRUCTURE
//  - Package seg_disp_pkg: OWN_BASE/OWN_SRC1/OWN_SRC2 codes, FSM state localparams IDLE/SHOW1/SHOW2.
//  - Sub-module ms_tick_gen (prescaler, sync clear input, 1-cycle tick out), instantiated once.
//  - FSM, pend/edge regs, hold counter, blink counter, output regs in this module.
// TESTING (TICK_DIV=4, HOLD_MS=3, BLINK_MS=2)
//  - Reset: rst_l=1 for 2 cycles -> owner=0, busy=0, ack=0, a1..a4=0, dig_blank=0.
//  - IDLE pass-through: base_digits=16'h1234 -> a1..a4=1,2,3,4 one cycle later; owner=0.
//  - src1 grant: req[0] 0->1, req_digits1=16'hA5C3 -> ack[0] 1-cycle pulse; owner=1 for 12 cycles,
//    a1..a4=A,5,C,3; then owner=0, base shown.
//  - Priority: req[0] and req[1] edges same cycle -> ack[1] first, owner=2 for 12 cycles;
//    then ack[0], owner=1 for 12 cycles; then IDLE.
//  - Preempt/retrigger: src2 edge during SHOW1 -> owner=2, src1 not reshown. Second src2 edge
//    8 cycles into SHOW2 -> ack[1], owner=2 for 12 cycles after it.
//  - Blink, reset mid-hold: blink_en=3'b100 in SHOW2 -> dig_blank toggles every 8 cycles.
//    rst_l=1 mid-hold -> IDLE, pend=0, no later grant.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared owner codes and FSM states for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam logic [1:0] OWN_BASE = 2'd0;
    localparam logic [1:0] OWN_SRC1 = 2'd1;
    localparam logic [1:0] OWN_SRC2 = 2'd2;

    // State encoding equals the owner code it shows.
    typedef enum logic [1:0] {
        IDLE  = OWN_BASE,
        SHOW1 = OWN_SRC1,
        SHOW2 = OWN_SRC2
    } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV cycles, synchronously clearable.
module ms_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_l || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates the 4-digit display between the base value and two
// transient sources, with timed hold and blink blanking.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int HOLD_MS  = 2000,
    parameter int BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [15:0] base_digits,
    input  logic [1:0]  req,
    input  logic [15:0] req_digits1,
    input  logic [15:0] req_digits2,
    input  logic [2:0]  blink_en,
    output logic [1:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [3:0]  a1,
    output logic [3:0]  a2,
    output logic [3:0]  a3,
    output logic [3:0]  a4,
    output logic        dig_blank
);

    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    state_t        state, state_n;
    logic [1:0]    req_q, pend, pend_n, rise, pe;
    logic          grant1, grant2, grant, expire, tick;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [15:0]   snap, shown;

    ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_l (rst_l),
        .clr   (grant),
        .tick  (tick)
    );

    // Edges are folded into pending before deciding, so an edge in the
    // expiry cycle is granted in the same transition.
    always_comb begin
        rise    = req & ~req_q;
        pe      = pend | rise;
        expire  = (state != IDLE) && tick && (hold_cnt == HOLD_LAST);
        grant1  = 1'b0;
        grant2  = 1'b0;
        state_n = state;
        unique case (state)
            IDLE: begin
                if (pe[1])      grant2 = 1'b1;
                else if (pe[0]) grant1 = 1'b1;
            end
            SHOW1: begin
                if (pe[1])       grant2 = 1'b1;
                else if (expire) begin
                    if (pe[0]) grant1 = 1'b1;
                    else       state_n = IDLE;
                end
            end
            SHOW2: begin
                if (rise[1] || (expire && pe[1])) grant2 = 1'b1;
                else if (expire) begin
                    if (pe[0]) grant1 = 1'b1;
                    else       state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (grant2)      state_n = SHOW2;
        else if (grant1) state_n = SHOW1;
        grant  = grant1 | grant2;
        pend_n = pe & ~{grant2, grant1};
        shown  = (state == IDLE) ? base_digits : snap;
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            state     <= IDLE;
            req_q     <= '0;
            pend      <= '0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            snap      <= '0;
            ack       <= '0;
            owner     <= OWN_BASE;
            busy      <= 1'b0;
            {a1, a2, a3, a4} <= '0;
            dig_blank <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= req;
            pend  <= pend_n;
            ack   <= {grant2, grant1};
            if (grant)
                hold_cnt <= '0;
            else if (tick && state != IDLE)
                hold_cnt <= hold_cnt + 1'b1;
            if (grant2)      snap <= req_digits2;
            else if (grant1) snap <= req_digits1;
            if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            owner            <= state;
            busy             <= (state != IDLE);
            {a1, a2, a3, a4} <= shown;
            dig_blank        <= blink_en[state] & phase;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter against a cycle-count reference model.
module tb_seg_display_arbiter;

    localparam int DIV   = 4;
    localparam int HOLD  = 3;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] base_digits, req_digits1, req_digits2;
    logic [1:0]  req;
    logic [2:0]  blink_en;
    logic [1:0]  ack, owner;
    logic        busy, dig_blank;
    logic [3:0]  a1, a2, a3, a4;

    int checks = 0;
    int errors = 0;

    seg_display_arbiter #(
        .TICK_DIV (DIV),
        .HOLD_MS  (HOLD),
        .BLINK_MS (BLINK)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .base_digits (base_digits),
        .req         (req),
        .req_digits1 (req_digits1),
        .req_digits2 (req_digits2),
        .blink_en    (blink_en),
        .ack         (ack),
        .owner       (owner),
        .busy        (busy),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .a4          (a4),
        .dig_blank   (dig_blank)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the display, cycles left in the hold,
    // cycles since the prescaler was last cleared, total ms ticks seen.
    int          m_own, m_left, m_since, m_ticks;
    logic [1:0]  m_pend, m_req_q;
    logic [15:0] m_snap;
    logic        m_phase;
    logic [1:0]  e_ack, e_owner;
    logic        e_busy, e_blank;
    logic [15:0] e_dig;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] rise, pe;
        logic g1, g2, expire, tick;
        if (rst_l) begin
            m_own = 0; m_left = 0; m_since = 0; m_ticks = 0;
            m_pend = 0; m_req_q = 0; m_snap = 0; m_phase = 0;
            e_ack = 0; e_owner = 0; e_busy = 0; e_blank = 0; e_dig = 0;
            return;
        end
        e_owner = 2'(m_own);
        e_busy  = (m_own != 0);
        e_dig   = (m_own == 0) ? base_digits : m_snap;
        e_blank = blink_en[m_own] & m_phase;
        rise   = req & ~m_req_q;
        pe     = m_pend | rise;
        tick   = (m_since % DIV) == DIV - 1;
        expire = 1'b0;
        if (m_own != 0) begin
            m_left--;
            expire = (m_left == 0);
        end
        g1 = 0; g2 = 0;
        if (m_own == 0) begin
            g2 = pe[1]; g1 = ~pe[1] & pe[0];
        end else if (m_own == 1) begin
            g2 = pe[1]; g1 = ~pe[1] & expire & pe[0];
        end else begin
            g2 = rise[1] | (expire & pe[1]);
            g1 = ~g2 & expire & pe[0];
        end
        e_ack   = {g2, g1};
        m_pend  = pe & ~{g2, g1};
        m_req_q = req;
        if (g2 || g1) begin
            m_own   = g2 ? 2 : 1;
            m_snap  = g2 ? req_digits2 : req_digits1;
            m_left  = HOLD * DIV;
            m_since = 0;
        end else begin
            if (expire) m_own = 0;
            m_since++;
        end
        if (tick) begin
            m_ticks++;
            m_phase = ((m_ticks / BLINK) % 2) == 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ack",   16'(ack),   16'(e_ack));
        chk("owner", 16'(owner), 16'(e_owner));
        chk("busy",  16'(busy),  16'(e_busy));
        chk("digits", {a1, a2, a3, a4}, e_dig);
        chk("blank", 16'(dig_blank), 16'(e_blank));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_l = 1; req = 0; blink_en = 0;
        base_digits = 0; req_digits1 = 0; req_digits2 = 0;
        @(negedge clk);
        run(2);
        rst_l = 0;
        base_digits = 16'h1234;
        run(3);
        req = 2'b01; req_digits1 = 16'hA5C3;
        run(16);
        req = 2'b00;
        run(2);
        req = 2'b11; req_digits1 = 16'h1111; req_digits2 = 16'h7777;
        run(30);
        req = 2'b00;
        run(2);
        req = 2'b01; req_digits1 = 16'hBEEF;
        run(4);
        req = 2'b11; req_digits2 = 16'hCAFE;
        run(8);
        req = 2'b00;
        run(1);
        req = 2'b10; req_digits2 = 16'h4242;
        run(16);
        blink_en = 3'b100;
        for (int k = 0; k < 4; k++) begin
            req = 2'b00;
            run(1);
            req = 2'b10;
            run(10);
        end
        rst_l = 1;
        run(1);
        rst_l = 0; req = 2'b00;
        run(20);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) req[0] = ~req[0];
            if ($urandom_range(9) == 0) req[1] = ~req[1];
            if ($urandom_range(49) == 0) blink_en = 3'($urandom);
            base_digits = 16'($urandom);
            req_digits1 = 16'($urandom);
            req_digits2 = 16'($urandom);
            rst_l = ($urandom_range(299) == 0);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
